// File: rtl/mem_stage_dmem_if.sv
// EX/MEM-side request bus into the data memory and its load/stall/error responses.
interface mem_stage_dmem_if;
  logic        MemWriteM;
  logic        MemReadM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        MisalignedM;

  modport master (
    output MemWriteM, MemReadM, Funct3M, ALUResultM, WriteDataM,
    input  ReadDataM, StallMem, MisalignedM
  );

  modport slave (
    input  MemWriteM, MemReadM, Funct3M, ALUResultM, WriteDataM,
    output ReadDataM, StallMem, MisalignedM
  );
endinterface

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: byte/half/word loads and stores with a fixed access
// latency; StallMem freezes the upstream pipeline until the access completes.
module mem_stage_dmem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  mem_stage_dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          err;
  logic          complete;
  logic          commit;
  logic          load_ok;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          unused_addr;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{ln, 3'b000} +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  assign req         = bus.MemReadM | bus.MemWriteM;
  assign lane        = bus.ALUResultM[1:0];
  assign word_idx    = bus.ALUResultM[AW+1:2];
  // Address bits above the array wrap and are deliberately ignored.
  assign unused_addr = ^bus.ALUResultM[31:AW+2];

  always_comb begin
    err = 1'b0;
    if (req) begin
      case (bus.Funct3M)
        3'b000, 3'b100: err = 1'b0;
        3'b001, 3'b101: err = lane[0];
        3'b010:         err = (lane != 2'b00);
        default:        err = 1'b1;
      endcase
    end
  end

  assign complete = err
                  | ((state == IDLE) & req & (LATENCY == 1))
                  | ((state == BUSY) & (cnt == CNT_LAST));

  assign commit  = complete & ~err & bus.MemWriteM & ~rst;
  assign load_ok = complete & ~err & bus.MemReadM & ~bus.MemWriteM & ~rst;

  assign bus.StallMem    = req & ~complete & ~rst;
  assign bus.MisalignedM = err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !err && (LATENCY > 1)) begin
            state <= BUSY;
            cnt   <= CW'(1);
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b1111;
    wdata = bus.WriteDataM;
    case (bus.Funct3M[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.WriteDataM[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.WriteDataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.WriteDataM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata         = mem[word_idx];
  assign bus.ReadDataM = load_ok ? load_extend(rdata, bus.Funct3M, lane) : 32'h0;
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Bench for mem_stage_dmem: three instances (LATENCY 1/2/4) checked against a
// byte-array reference model with directed and randomized accesses.
module tb_mem_stage_dmem;
  logic        clk = 1'b0;
  logic        rst;
  logic        mw, mr;
  logic [2:0]  f3;
  logic [31:0] addr, wd;
  int          sel = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mdl [3][4096];

  typedef struct {
    logic        w;
    logic        r;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    int          st;
    logic        mis;
    logic [31:0] rd;
  } vec_t;

  always #5 clk = ~clk;

  mem_stage_dmem_if b0 ();
  mem_stage_dmem_if b1 ();
  mem_stage_dmem_if b2 ();

  assign b0.MemWriteM  = mw & (sel == 0);
  assign b0.MemReadM   = mr & (sel == 0);
  assign b0.Funct3M    = f3;
  assign b0.ALUResultM = addr;
  assign b0.WriteDataM = wd;
  assign b1.MemWriteM  = mw & (sel == 1);
  assign b1.MemReadM   = mr & (sel == 1);
  assign b1.Funct3M    = f3;
  assign b1.ALUResultM = addr;
  assign b1.WriteDataM = wd;
  assign b2.MemWriteM  = mw & (sel == 2);
  assign b2.MemReadM   = mr & (sel == 2);
  assign b2.Funct3M    = f3;
  assign b2.ALUResultM = addr;
  assign b2.WriteDataM = wd;

  mem_stage_dmem #(.DEPTH_WORDS(16),   .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(b0));
  mem_stage_dmem #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(b1));
  mem_stage_dmem #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(b2));

  function automatic logic [33:0] outs();
    case (sel)
      0:       return {b0.StallMem, b0.MisalignedM, b0.ReadDataM};
      1:       return {b1.StallMem, b1.MisalignedM, b1.ReadDataM};
      default: return {b2.StallMem, b2.MisalignedM, b2.ReadDataM};
    endcase
  endfunction

  function automatic int lat(int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
  endfunction

  function automatic int dbytes(int s);
    return (s == 0) ? 64 : 4096;
  endfunction

  function automatic bit m_err(logic [2:0] f, logic [31:0] a);
    case (f)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return (a % 2) != 0;
      3'b010:         return (a % 4) != 0;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_load(int s, logic [2:0] f, logic [31:0] a);
    int nb = 1 << f[1:0];
    int base = int'(a % 32'(dbytes(s)));
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(mdl[s][base+i]) << (8*i));
    if (!f[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  function automatic void m_store(int s, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    int nb = 1 << f[1:0];
    int base = int'(a % 32'(dbytes(s)));
    for (int i = 0; i < nb; i++) mdl[s][base+i] = d[8*i +: 8];
  endfunction

  // Presents one request at posedge+1 and holds it until StallMem drops.
  task automatic xact(input logic w, input logic r, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      output int stalls, output logic [31:0] rd, output logic mis);
    logic [33:0] o;
    bit done = 1'b0;
    mw = w; mr = r; f3 = f; addr = a; wd = d;
    stalls = 0; rd = 32'h0; mis = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      o = outs();
      if (o[33]) stalls++;
      else begin
        rd = o[31:0];
        mis = o[32];
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    mw = 1'b0; mr = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: access at %h still stalled after %0d cycles, want %0d", a, stalls, lat(sel) - 1);
    end
    if (w && !m_err(f, a)) m_store(sel, f, a, d);
  endtask

  task automatic test_reset();
    logic [33:0] o;
    rst = 1'b1; sel = 1; mr = 1'b1; mw = 1'b0; f3 = 3'b011; addr = 32'h11; wd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = outs();
    checks++;
    if (o !== 34'h0) begin
      errors++;
      $display("FAIL reset_illegal: got stall/mis/rd %h, want 0", o);
    end
    mw = 1'b1; f3 = 3'b010; addr = 32'h10;
    @(negedge clk);
    o = outs();
    checks++;
    if (o !== 34'h0) begin
      errors++;
      $display("FAIL reset_legal: got stall/mis/rd %h, want 0", o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; mw = 1'b0; mr = 1'b0;
    @(negedge clk);
    checks++;
    if ({b0.StallMem, b0.MisalignedM, b0.ReadDataM, b1.StallMem, b1.MisalignedM, b1.ReadDataM,
         b2.StallMem, b2.MisalignedM, b2.ReadDataM} !== 102'h0) begin
      errors++;
      $display("FAIL idle_outputs: got %h/%h/%h, want all 0", b0.ReadDataM, b1.ReadDataM, b2.ReadDataM);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    int st; logic [31:0] rd; logic mis;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int a = 0; a < ((s == 0) ? 64 : 128); a += 4) begin
        xact(1'b1, 1'b0, 3'b010, 32'(a), $urandom, st, rd, mis);
        checks++;
        if (st != lat(s) - 1 || mis !== 1'b0) begin
          errors++;
          $display("FAIL fill_sw: lat%0d addr %0h got stall %0d mis %b, want %0d 0", lat(s), a, st, mis, lat(s) - 1);
        end
      end
    end
  endtask

  task automatic test_l2_widths();
    vec_t t[$];
    int st; logic [31:0] rd; logic mis;
    sel = 1;
    t.push_back('{1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b010, 32'h10, 32'h0,        1, 1'b0, 32'hDEADBEEF});
    t.push_back('{1'b1, 1'b0, 3'b000, 32'h13, 32'h12345680, 1, 1'b0, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b000, 32'h13, 32'h0,        1, 1'b0, 32'hFFFFFF80});
    t.push_back('{1'b0, 1'b1, 3'b100, 32'h13, 32'h0,        1, 1'b0, 32'h00000080});
    t.push_back('{1'b0, 1'b1, 3'b010, 32'h10, 32'h0,        1, 1'b0, 32'h80ADBEEF});
    t.push_back('{1'b1, 1'b0, 3'b001, 32'h12, 32'hABCD8001, 1, 1'b0, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b001, 32'h12, 32'h0,        1, 1'b0, 32'hFFFF8001});
    t.push_back('{1'b0, 1'b1, 3'b101, 32'h12, 32'h0,        1, 1'b0, 32'h00008001});
    t.push_back('{1'b0, 1'b1, 3'b010, 32'h11, 32'h0,        0, 1'b1, 32'h0});
    t.push_back('{1'b1, 1'b0, 3'b010, 32'h11, 32'h55555555, 0, 1'b1, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b001, 32'h13, 32'h0,        0, 1'b1, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b010, 32'h10, 32'h0,        1, 1'b0, 32'h8001BEEF});
    t.push_back('{1'b1, 1'b1, 3'b010, 32'h14, 32'h11223344, 1, 1'b0, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b010, 32'h14, 32'h0,        1, 1'b0, 32'h11223344});
    foreach (t[i]) begin
      xact(t[i].w, t[i].r, t[i].f, t[i].a, t[i].d, st, rd, mis);
      checks++;
      if (st != t[i].st || mis !== t[i].mis || rd !== t[i].rd) begin
        errors++;
        $display("FAIL l2_vec%0d: got stall %0d mis %b rd %h, want %0d %b %h",
                 i, st, mis, rd, t[i].st, t[i].mis, t[i].rd);
      end
    end
  endtask

  task automatic test_l1_alias();
    vec_t t[$];
    int st; logic [31:0] rd; logic mis;
    sel = 0;
    t.push_back('{1'b1, 1'b0, 3'b010, 32'h10,       32'hCAFEF00D, 0, 1'b0, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b010, 32'h50,       32'h0,        0, 1'b0, 32'hCAFEF00D});
    t.push_back('{1'b1, 1'b0, 3'b000, 32'h51,       32'h0000007F, 0, 1'b0, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b010, 32'h10,       32'h0,        0, 1'b0, 32'hCAFE7F0D});
    t.push_back('{1'b0, 1'b1, 3'b000, 32'h11,       32'h0,        0, 1'b0, 32'h0000007F});
    t.push_back('{1'b0, 1'b1, 3'b011, 32'h10,       32'h0,        0, 1'b1, 32'h0});
    t.push_back('{1'b1, 1'b0, 3'b110, 32'h10,       32'h0,        0, 1'b1, 32'h0});
    t.push_back('{1'b0, 1'b1, 3'b010, 32'hFFFF0010, 32'h0,        0, 1'b0, 32'hCAFE7F0D});
    foreach (t[i]) begin
      xact(t[i].w, t[i].r, t[i].f, t[i].a, t[i].d, st, rd, mis);
      checks++;
      if (st != t[i].st || mis !== t[i].mis || rd !== t[i].rd) begin
        errors++;
        $display("FAIL l1_vec%0d: got stall %0d mis %b rd %h, want %0d %b %h",
                 i, st, mis, rd, t[i].st, t[i].mis, t[i].rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int st1, st2; logic [31:0] rd, exp, v; logic mis;
    sel = 2;
    exp = m_load(2, 3'b010, 32'h10);
    xact(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, st1, rd, mis);
    checks++;
    if (st1 != 3 || rd !== exp) begin
      errors++;
      $display("FAIL l4_load: got stall %0d rd %h, want 3 %h", st1, rd, exp);
    end
    v = $urandom;
    xact(1'b1, 1'b0, 3'b010, 32'h40, v, st1, rd, mis);
    xact(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, st2, rd, mis);
    checks++;
    if (st1 + st2 + 2 != 8) begin
      errors++;
      $display("FAIL l4_b2b_cycles: got %0d cycles, want 8", st1 + st2 + 2);
    end
    checks++;
    if (rd !== v) begin
      errors++;
      $display("FAIL l4_b2b_data: got %h, want %h", rd, v);
    end
  endtask

  task automatic test_reset_abort();
    logic [33:0] o;
    int st; logic [31:0] rd, prior; logic mis;
    sel = 2;
    prior = m_load(2, 3'b010, 32'h20);
    mw = 1'b1; mr = 1'b0; f3 = 3'b010; addr = 32'h20; wd = ~prior;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    o = outs();
    checks++;
    if (o !== 34'h0) begin
      errors++;
      $display("FAIL abort_outputs: got stall/mis/rd %h, want 0", o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; mw = 1'b0;
    xact(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, st, rd, mis);
    checks++;
    if (rd !== prior || st != 3) begin
      errors++;
      $display("FAIL abort_no_commit: got rd %h stall %0d, want %h 3", rd, st, prior);
    end
  endtask

  task automatic test_random();
    int st, k, est; logic [31:0] rd, a, d, erd; logic mis, w, r, e; logic [2:0] f;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 80; n++) begin
        k = $urandom_range(9, 0);
        w = (k >= 5); r = (k < 5) || (k == 9);
        f = 3'($urandom_range(7, 0));
        a = ($urandom & ~32'(dbytes(s) - 1)) | ($urandom & ((s == 0) ? 32'd63 : 32'd127));
        if ($urandom_range(1, 0) == 1) a = a & ~32'd3;
        d = $urandom;
        e = m_err(f, a);
        est = e ? 0 : lat(s) - 1;
        erd = (r && !w && !e) ? m_load(s, f, a) : 32'h0;
        xact(w, r, f, a, d, st, rd, mis);
        checks++;
        if (st != est) begin
          errors++;
          $display("FAIL rnd_stall: lat%0d f3 %b addr %h got %0d, want %0d", lat(s), f, a, st, est);
        end
        checks++;
        if (mis !== e) begin
          errors++;
          $display("FAIL rnd_mis: lat%0d f3 %b addr %h got %b, want %b", lat(s), f, a, mis, e);
        end
        checks++;
        if (rd !== erd) begin
          errors++;
          $display("FAIL rnd_rd: lat%0d w%b r%b f3 %b addr %h got %h, want %h", lat(s), w, r, f, a, rd, erd);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mw = 1'b0; mr = 1'b0; f3 = 3'b000; addr = 32'h0; wd = 32'h0; rst = 1'b1;
    test_reset();
    test_fill();
    test_l2_widths();
    test_l1_alias();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
